// File: rtl/fp_stream_accumulator.sv
// -----------------------------------------------------------------------------
// fp_stream_accumulator
//   Reduces a valid/ready stream of IEEE-754 operands into a single packet sum.
//   Each beat is added to or subtracted from a running accumulator through one
//   combinational fpaddsub instance.  When the beat flagged last has been
//   folded in, the sum, the beat count and status flags are presented on a
//   valid/ready output port until the consumer takes them.
//
// Ports
//   clk, rst      single rising-edge clock, asynchronous active-high reset
//   in_valid      input beat valid
//   in_ready      input beat accepted when in_valid && in_ready (low in HOLD)
//   in_data       IEEE operand, W = 2**LOG_BIT bits
//   in_sub        1: subtract in_data from the accumulator, 0: add it
//   in_last       final beat of the packet
//   out_valid     packet result valid
//   out_ready     consumer accepts the result
//   out_data      packet sum
//   out_count     beats in the packet, saturating at 2**CNT_BIT-1
//   out_nan       out_data is a NaN
//   out_inf       out_data is +/-inf
//   out_ovf       some step produced inf from two finite operands
//
// fpaddsub
//   Combinational IEEE-754 adder/subtractor, round-to-nearest-even, with
//   gradual underflow.  addnot_sub=1 gives a+b, addnot_sub=0 gives a-b.
//   NaN inputs are propagated quietened (a before b); inf-inf gives the
//   default quiet NaN.
// -----------------------------------------------------------------------------

module fpaddsub #(
    parameter int LOG_BIT = 6,
    parameter int EXP_BIT = 11
) (
    input  logic [2**LOG_BIT-1:0] a,
    input  logic [2**LOG_BIT-1:0] b,
    input  logic                  addnot_sub,
    output logic [2**LOG_BIT-1:0] result
);
    localparam int W   = 2**LOG_BIT;
    localparam int M   = W - 1 - EXP_BIT;
    // hidden bit + mantissa + guard/round/sticky
    localparam int XW  = M + 4;
    localparam int EW  = EXP_BIT + 2;
    localparam int LZW = $clog2(XW + 1);
    localparam logic [EXP_BIT-1:0] EXP_ONES = '1;

    logic [EXP_BIT-1:0] w_a_exp, w_b_exp;
    logic [M-1:0]       w_a_man, w_b_man;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic               w_b_sign;

    logic               w_swap;
    logic               w_l_sign, w_s_sign;
    logic [EXP_BIT-1:0] w_l_exp, w_s_exp;
    logic [M-1:0]       w_l_man, w_s_man;
    logic [M:0]         w_l_sig, w_s_sig;
    logic [EW-1:0]      w_l_eexp, w_s_eexp, w_diff, w_shamt;

    logic [2*XW-1:0]    w_wide;
    logic [XW-1:0]      w_l_ext, w_s_al;
    logic               w_eff_sub;
    logic [XW:0]        w_sum;

    logic [LZW-1:0]     w_lz;
    logic [EW-1:0]      w_limit, w_nsh, w_e_n, w_e_f;
    logic [XW-1:0]      w_norm;
    logic [M:0]         w_mant;
    logic               w_rnd_up;
    logic [M+1:0]       w_rounded;
    logic [M-1:0]       w_man_f;

    // operand classification; b carries the effective sign of the operation
    assign w_a_exp  = a[W-2:M];
    assign w_b_exp  = b[W-2:M];
    assign w_a_man  = a[M-1:0];
    assign w_b_man  = b[M-1:0];
    assign w_a_nan  = (w_a_exp == EXP_ONES) && (w_a_man != '0);
    assign w_b_nan  = (w_b_exp == EXP_ONES) && (w_b_man != '0);
    assign w_a_inf  = (w_a_exp == EXP_ONES) && (w_a_man == '0);
    assign w_b_inf  = (w_b_exp == EXP_ONES) && (w_b_man == '0);
    assign w_b_sign = b[W-1] ^ ~addnot_sub;

    // order operands so that |L| >= |S|
    assign w_swap   = {w_b_exp, w_b_man} > {w_a_exp, w_a_man};
    assign w_l_sign = w_swap ? w_b_sign : a[W-1];
    assign w_s_sign = w_swap ? a[W-1]   : w_b_sign;
    assign w_l_exp  = w_swap ? w_b_exp  : w_a_exp;
    assign w_s_exp  = w_swap ? w_a_exp  : w_b_exp;
    assign w_l_man  = w_swap ? w_b_man  : w_a_man;
    assign w_s_man  = w_swap ? w_a_man  : w_b_man;

    // subnormals: hidden bit 0, effective exponent 1
    assign w_l_sig  = {(w_l_exp != '0), w_l_man};
    assign w_s_sig  = {(w_s_exp != '0), w_s_man};
    assign w_l_eexp = (w_l_exp == '0) ? EW'(1) : {2'b00, w_l_exp};
    assign w_s_eexp = (w_s_exp == '0) ? EW'(1) : {2'b00, w_s_exp};
    assign w_diff   = w_l_eexp - w_s_eexp;
    // any shift of XW or more moves every bit into the sticky position
    assign w_shamt  = (w_diff > EW'(XW)) ? EW'(XW + 1) : w_diff;

    // align S; the lower half of the double-width shift collapses into sticky
    assign w_wide    = {w_s_sig, 3'b000, {XW{1'b0}}} >> w_shamt;
    assign w_s_al    = {w_wide[2*XW-1:XW+1], w_wide[XW] | (|w_wide[XW-1:0])};
    assign w_l_ext   = {w_l_sig, 3'b000};
    assign w_eff_sub = w_l_sign ^ w_s_sign;
    assign w_sum     = w_eff_sub ? ({1'b0, w_l_ext} - {1'b0, w_s_al})
                                 : ({1'b0, w_l_ext} + {1'b0, w_s_al});

    // leading-zero count of the non-carry part
    always_comb begin
        w_lz = LZW'(XW);
        for (int unsigned i = 0; i < XW; i++) begin
            if (w_sum[i]) w_lz = LZW'(XW - 1 - i);
        end
    end

    // normalise; left shift is capped so the exponent never drops below 1,
    // which leaves a subnormal with its leading bit clear
    always_comb begin
        w_limit = w_l_eexp - EW'(1);
        w_nsh   = '0;
        w_norm  = '0;
        w_e_n   = w_l_eexp;
        if (w_sum[XW]) begin
            w_norm = {w_sum[XW:2], w_sum[1] | w_sum[0]};
            w_e_n  = w_l_eexp + EW'(1);
        end else begin
            w_nsh  = (EW'(w_lz) > w_limit) ? w_limit : EW'(w_lz);
            w_norm = w_sum[XW-1:0] << w_nsh;
            w_e_n  = w_l_eexp - w_nsh;
        end
    end

    // round to nearest, ties to even
    assign w_mant    = w_norm[XW-1:3];
    assign w_rnd_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_mant[0]);
    assign w_rounded = {1'b0, w_mant} + (M+2)'(w_rnd_up);

    always_comb begin
        w_e_f   = '0;
        w_man_f = '0;
        if (w_rounded[M+1]) begin
            w_e_f   = w_e_n + EW'(1);
            w_man_f = w_rounded[M:1];
        end else begin
            // a subnormal that rounds up into bit M becomes the smallest normal
            w_e_f   = w_rounded[M] ? w_e_n : '0;
            w_man_f = w_rounded[M-1:0];
        end
    end

    always_comb begin
        result = '0;
        if (w_a_nan) begin
            result = {a[W-1], EXP_ONES, 1'b1, w_a_man[M-2:0]};
        end else if (w_b_nan) begin
            result = {b[W-1], EXP_ONES, 1'b1, w_b_man[M-2:0]};
        end else if (w_a_inf && w_b_inf) begin
            if (a[W-1] == w_b_sign) result = a;
            else                    result = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
        end else if (w_a_inf) begin
            result = a;
        end else if (w_b_inf) begin
            result = {w_b_sign, b[W-2:0]};
        end else if (w_sum == '0) begin
            // exact zero is +0 unless both operands are -0
            result = {a[W-1] & w_b_sign, {(W-1){1'b0}}};
        end else if (w_e_f >= {2'b00, EXP_ONES}) begin
            result = {w_l_sign, EXP_ONES, {M{1'b0}}};
        end else begin
            result = {w_l_sign, w_e_f[EXP_BIT-1:0], w_man_f};
        end
    end
endmodule

module fp_stream_accumulator #(
    parameter int LOG_BIT = 6,
    parameter int EXP_BIT = 11,
    parameter int CNT_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2**LOG_BIT-1:0] in_data,
    input  logic                  in_sub,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**LOG_BIT-1:0] out_data,
    output logic [CNT_BIT-1:0]    out_count,
    output logic                  out_nan,
    output logic                  out_inf,
    output logic                  out_ovf
);
    localparam int W = 2**LOG_BIT;
    localparam int M = W - 1 - EXP_BIT;
    localparam logic [EXP_BIT-1:0] EXP_ONES = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             r_state, w_state_next;
    logic [W-1:0]       r_acc;
    logic [CNT_BIT-1:0] r_count;
    logic               r_ovf;
    logic [W-1:0]       r_out_data;
    logic [CNT_BIT-1:0] r_out_count;
    logic               r_out_nan, r_out_inf, r_out_ovf;

    logic               w_in_ready, w_out_valid;
    logic               w_accept, w_first, w_out_done;
    logic [W-1:0]       w_step_res, w_acc_next;
    logic [CNT_BIT-1:0] w_count_next;
    logic               w_step_ovf, w_ovf_next;
    logic               w_next_nan, w_next_inf;

    fpaddsub #(
        .LOG_BIT(LOG_BIT),
        .EXP_BIT(EXP_BIT)
    ) u_fpaddsub (
        .a         (r_acc),
        .b         (in_data),
        .addnot_sub(~in_sub),
        .result    (w_step_res)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = in_last ? HOLD : ACCUM;
            ACCUM:   if (w_accept && in_last) w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        w_in_ready  = (r_state != HOLD);
        w_out_valid = (r_state == HOLD);
    end

    assign w_accept   = in_valid && w_in_ready;
    assign w_first    = (r_state == IDLE);
    assign w_out_done = w_out_valid && out_ready;

    // first beat bypasses the adder so -0 and NaN payloads survive unchanged
    assign w_acc_next = !w_first ? w_step_res
                      : (in_sub ? {~in_data[W-1], in_data[W-2:0]} : in_data);

    assign w_count_next = w_first ? CNT_BIT'(1)
                        : ((r_count == '1) ? r_count : r_count + CNT_BIT'(1));

    assign w_step_ovf = (w_step_res[W-2:M] == EXP_ONES) && (w_step_res[M-1:0] == '0)
                     && (r_acc[W-2:M] != EXP_ONES) && (in_data[W-2:M] != EXP_ONES);
    assign w_ovf_next = w_first ? 1'b0 : (r_ovf | w_step_ovf);

    assign w_next_nan = (w_acc_next[W-2:M] == EXP_ONES) && (w_acc_next[M-1:0] != '0);
    assign w_next_inf = (w_acc_next[W-2:M] == EXP_ONES) && (w_acc_next[M-1:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_nan   <= 1'b0;
            r_out_inf   <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            if (in_last) begin
                r_out_data  <= w_acc_next;
                r_out_count <= w_count_next;
                r_out_nan   <= w_next_nan;
                r_out_inf   <= w_next_inf;
                r_out_ovf   <= w_ovf_next;
            end
        end else if (w_out_done) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_nan   = r_out_nan;
    assign out_inf   = r_out_inf;
    assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fp_stream_accumulator
//   Table of packets with hand-derived sums plus hand-written sequences for
//   latency, backpressure, count saturation and mid-packet reset.  Expected
//   results are queued when the last beat is driven and checked by a monitor
//   when the output handshake occurs.  The DUT uses a 3-bit beat counter so
//   saturation is reachable in a few beats.
// -----------------------------------------------------------------------------

module tb_fp_stream_accumulator;
    localparam int LOG_BIT = 6;
    localparam int EXP_BIT = 11;
    localparam int CNT     = 3;
    localparam int W       = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_sub, in_last;
    logic [W-1:0]   in_data;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_data;
    logic [CNT-1:0] out_count;
    logic           out_nan, out_inf, out_ovf;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0]   d;
        logic [CNT-1:0] c;
        logic           nan, inf, ovf;
    } exp_t;

    typedef struct {
        int              n;
        logic [2:0][W-1:0] d;
        logic [2:0]      s;
        exp_t            x;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    fp_stream_accumulator #(
        .LOG_BIT(LOG_BIT),
        .EXP_BIT(EXP_BIT),
        .CNT_BIT(CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sub   (in_sub),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_nan  (out_nan),
        .out_inf  (out_inf),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: result taken on the edge after this negedge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %h, expected no result", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data",  out_data,        e.d);
                chk("out_count", W'(out_count),   W'(e.c));
                chk("out_nan",   W'(out_nan),     W'(e.nan));
                chk("out_inf",   W'(out_inf),     W'(e.inf));
                chk("out_ovf",   W'(out_ovf),     W'(e.ovf));
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_beat(input logic [W-1:0] d, input logic s, input logic l, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL result_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int n, input logic [W-1:0] d0, d1, d2,
                                input logic [2:0] s, input logic [W-1:0] xd,
                                input logic [CNT-1:0] xc, input logic xn, xi, xo);
        vec_t v;
        v.n = n;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        v.s = s;
        v.x.d = xd; v.x.c = xc; v.x.nan = xn; v.x.inf = xi; v.x.ovf = xo;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        exp_t e;
        // s bits: bit k = in_sub of beat k
        vecs[0]  = mk(1, 64'h4000000000000000, 0, 0, 3'b001, 64'hC000000000000000, 1, 0, 0, 0);
        vecs[1]  = mk(1, 64'h8000000000000000, 0, 0, 3'b000, 64'h8000000000000000, 1, 0, 0, 0);
        vecs[2]  = mk(2, 64'h7FF0000000000000, 64'hFFF0000000000000, 0, 3'b000,
                      64'h7FF8000000000000, 2, 1, 0, 0);
        vecs[3]  = mk(2, 64'h4014000000000000, 64'h4014000000000000, 0, 3'b010,
                      64'h0000000000000000, 2, 0, 0, 0);
        vecs[4]  = mk(2, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 0, 3'b000,
                      64'h7FF0000000000000, 2, 0, 1, 1);
        vecs[5]  = mk(1, 64'h3FF0000000000000, 0, 0, 3'b000, 64'h3FF0000000000000, 1, 0, 0, 0);
        vecs[6]  = mk(2, 64'h3FF0000000000000, 64'h3CA0000000000000, 0, 3'b000,
                      64'h3FF0000000000000, 2, 0, 0, 0);
        vecs[7]  = mk(2, 64'h3FF0000000000000, 64'h3CB0000000000000, 0, 3'b000,
                      64'h3FF0000000000001, 2, 0, 0, 0);
        vecs[8]  = mk(2, 64'h0000000000000001, 64'h0000000000000001, 0, 3'b000,
                      64'h0000000000000002, 2, 0, 0, 0);
        vecs[9]  = mk(2, 64'h0010000000000000, 64'h0000000000000001, 0, 3'b010,
                      64'h000FFFFFFFFFFFFF, 2, 0, 0, 0);
        vecs[10] = mk(3, 64'h3FF0000000000000, 64'h4000000000000000, 64'h3FE0000000000000, 3'b110,
                      64'hBFF8000000000000, 3, 0, 0, 0);
        vecs[11] = mk(2, 64'h7FF0000000000000, 64'h3FF0000000000000, 0, 3'b000,
                      64'h7FF0000000000000, 2, 0, 1, 0);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_count", W'(out_count), 0);
        chk("rst_flags",     W'({out_nan, out_inf, out_ovf}), 0);
        chk("rst_in_ready",  W'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1 + 2 + 3: latency and one-cycle in_ready drop
        out_ready = 1'b1;
        send_beat(64'h3FF0000000000000, 0, 0, w);
        chk("mid_out_valid", W'(out_valid), 0);
        send_beat(64'h4000000000000000, 0, 0, w);
        e.d = 64'h4018000000000000; e.c = 3; e.nan = 0; e.inf = 0; e.ovf = 0;
        sb.push_back(e);
        send_beat(64'h4008000000000000, 0, 1, w);
        chk("lat_out_valid", W'(out_valid), 1);
        chk("lat_in_ready",  W'(in_ready), 0);
        @(posedge clk); #1;
        chk("post_in_ready",  W'(in_ready), 1);
        chk("post_out_valid", W'(out_valid), 0);
        wait_drain();

        foreach (vecs[i]) begin
            for (int b = 0; b < vecs[i].n; b++) begin
                if (b == vecs[i].n - 1) sb.push_back(vecs[i].x);
                send_beat(vecs[i].d[b], vecs[i].s[b], (b == vecs[i].n - 1), w);
            end
            wait_drain();
        end

        // count saturation: nine beats of 1.0
        e.d = 64'h4022000000000000; e.c = 7; e.nan = 0; e.inf = 0; e.ovf = 0;
        for (int b = 0; b < 9; b++) begin
            if (b == 8) sb.push_back(e);
            send_beat(64'h3FF0000000000000, 0, (b == 8), w);
        end
        wait_drain();

        // backpressure: result held, input ignored
        out_ready = 1'b0;
        e.d = 64'h3FF0000000000000; e.c = 1; e.nan = 0; e.inf = 0; e.ovf = 0;
        sb.push_back(e);
        send_beat(64'h3FF0000000000000, 0, 1, w);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_sub   = 1'($urandom);
            in_last  = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", W'(out_valid), 1);
            chk("bp_out_data",  out_data, 64'h3FF0000000000000);
            chk("bp_out_count", W'(out_count), 1);
            chk("bp_in_ready",  W'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("bp_idle_in_ready",  W'(in_ready), 1);
        chk("bp_idle_out_valid", W'(out_valid), 0);
        e.d = 64'h4000000000000000; e.c = 1;
        sb.push_back(e);
        send_beat(64'h4000000000000000, 0, 1, w);
        chk("bp_next_wait", W'(w), 0);
        chk("bp_next_valid", W'(out_valid), 1);
        wait_drain();

        // asynchronous reset after two of three beats
        send_beat(64'h3FF0000000000000, 0, 0, w);
        send_beat(64'h4000000000000000, 0, 0, w);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_data",  out_data, 0);
        chk("arst_out_count", W'(out_count), 0);
        chk("arst_out_valid", W'(out_valid), 0);
        chk("arst_in_ready",  W'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        e.d = 64'h3FF0000000000000; e.c = 1; e.nan = 0; e.inf = 0; e.ovf = 0;
        sb.push_back(e);
        send_beat(64'h3FF0000000000000, 0, 1, w);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
